rgb_block_avg: RTL and testbench
================================

# rgb_block_avg

- Upstream stage of `RGBSort` in the klotski camera path.
- Watches the camera pixel stream for one full frame and averages the RGB of a central sampling window in each cell of a 4x4 grid.
- Presents the 16 block colours on `o_block0..o_block15` with a level `o_done`.
- These outputs connect directly to `RGBSort` `i_block*` / `i_start`.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `X0`, 64: x of grid top-left corner.
- `Y0`, 0: y of grid top-left corner.
- `TILE_LOG2`, 7: tile side = 2^TILE_LOG2 px (128).
- `WIN_LOG2`, 6: sampling window side = 2^WIN_LOG2 px (64), centred in tile; requires `WIN_LOG2 < TILE_LOG2`.

Ports:
- `i_clk`  in  1  pixel clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_start`  in  1  one-cycle request to capture the next frame.
- `i_valid`  in  1  pixel qualifier.
- `i_x`  in  11  pixel column.
- `i_y`  in  10  pixel row.
- `i_rgb`  in  24  pixel, {R,G,B}, 8 bits each.
- `o_block0`..`o_block15`  out  24  averaged colour per tile, row-major (block0 top-left, block3 top-right, block15 bottom-right).
- `o_done`  out  1  high while `o_block*` hold a completed capture.

## Operation
- FSM states: `IDLE`, `WAIT_SOF`, `ACCUM`, `LATCH`, `DONE`.
- `IDLE` / `DONE` + `i_start` -> `WAIT_SOF`:
  - Clears all 48 accumulators.
  - Drops `o_done`.
  - Keeps old `o_block*` until `LATCH`.
- `WAIT_SOF`: waits for `i_valid` at (0,0), then -> `ACCUM`. That pixel is accumulated (it lies outside any window at default parameters).
- `ACCUM`: each valid pixel goes through a one-stage register (tile index, in-window flag, rgb), then the channel sums of that tile are updated.
- Tile mapping:
  - dx = x - X0, dy = y - Y0.
  - tx = dx >> TILE_LOG2, ty likewise; valid only if 0 <= tx,ty <= 3.
  - Offset in tile is ox = dx mod 2^TILE_LOG2 (oy likewise).
  - In-window when ox and oy are both in [M, M + 2^WIN_LOG2), where M = (2^TILE_LOG2 - 2^WIN_LOG2)/2.
- Pixels outside the grid, outside a window, or with coordinates >= H_ACTIVE/V_ACTIVE are ignored.
- Valid pixel at (H_ACTIVE-1, V_ACTIVE-1) -> `LATCH`, after the pipeline stage drains.
- `LATCH`: each channel average = sum >> (2*WIN_LOG2). This is exact because the window pixel count is a power of two. Averages, optionally quantised, are registered into `o_block*`, then -> `DONE`.
- `DONE`: `o_done` = 1; `o_block*` are stable until the next `LATCH`.
- Accumulator width: 8 + 2*WIN_LOG2 bits per channel (20 at default); no overflow possible.
- `i_valid` gaps are allowed anywhere; the state is held through them.
- `i_start` in `WAIT_SOF` or `ACCUM`: restart; accumulators are cleared and the FSM returns to `WAIT_SOF`.
- `i_start` in the same cycle as the last pixel: the start wins; no `LATCH`.

## Timing
- Reset values:
  - All `o_block*` = 24'h000000.
  - `o_done` = 0.
  - State = `IDLE`.
  - Accumulators = 0.
- Reset mid-frame aborts immediately; no partial result is ever presented.
- Latency: `o_done` rises 3 cycles after the clock edge sampling the last frame pixel (pipeline, add, latch).
- `o_done` falls on the cycle after `i_start` is sampled.
- Throughput: one pixel per clock, sustained.
- Capture time: at most two frames after `i_start` (a partial frame, then one full frame).

## Configuration
- `RGB_QUANT_EN` defined:
  - In `LATCH`, each channel is snapped to the `RGBSort` levels: < 8'h40 -> 8'h00; < 8'hC0 -> 8'h7F; else 8'hFF.
  - Output colours are exactly the 16 legal tile codes.
- Not defined: raw truncated averages are output.

## Structure
- Shared package `klotski_pkg`:
  - `NUM_BLOCKS` = 16, `GRID` = 4.
  - `rgb_t` (24-bit packed {r,g,b}).
  - Quantisation levels and thresholds.
  - `rgb_avg_state_t` enum.
  - `RGBSort` uses the same package.
- Sub-module `rgb_quantize`: combinational 24-bit in / 24-bit out.
  - Instantiated 16x under `RGB_QUANT_EN`.
  - Separately testable.

## Test plan
- Reset with no stimulus -> all `o_block*` = 0, `o_done` = 0 indefinitely.
- Solid-fill frame, every pixel 24'h7F00FF, start pulsed -> `o_done` 3 cycles after last pixel; all 16 blocks = 24'h7F00FF.
- Frame where each tile window holds the k-th `RGBSort` code in a scrambled order (9, 5, 3, 7, ... 12) -> `o_block*` reproduce the order; the `RGBSort` chain then outputs the matching 4-bit order word.
- `RGB_QUANT_EN` with window pixels alternating 24'h7F7F7F / 24'h818181 (mean 24'h808080), and non-window pixels 24'hFFFFFF -> blocks = 24'h7F7F7F.
- `i_start` re-pulsed mid-`ACCUM`, then a clean frame -> result reflects only the second frame; no `o_done` in between.
- `i_valid` toggled 50% randomly, plus async reset pulsed at row 200 -> outputs zero immediately; after restart, results match the gap-free run.

Source files
------------

// File: rtl/klotski_pkg.sv
// Shared types, levels and helpers for the klotski camera path
// (rgb_block_avg and RGBSort).
package klotski_pkg;

    localparam int NUM_BLOCKS = 16;
    localparam int GRID       = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam logic [7:0] QLVL_LO  = 8'h00;
    localparam logic [7:0] QLVL_MID = 8'h7F;
    localparam logic [7:0] QLVL_HI  = 8'hFF;
    localparam logic [7:0] QTHR_LO  = 8'h40;
    localparam logic [7:0] QTHR_HI  = 8'hC0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SOF = 3'd1,
        ACCUM    = 3'd2,
        LATCH    = 3'd3,
        DONE     = 3'd4
    } rgb_avg_state_t;

    function automatic logic [7:0] quant_chan(input logic [7:0] c);
        logic [7:0] q;
        if (c < QTHR_LO) begin
            q = QLVL_LO;
        end else if (c < QTHR_HI) begin
            q = QLVL_MID;
        end else begin
            q = QLVL_HI;
        end
        return q;
    endfunction

endpackage

// File: rtl/rgb_quantize.sv
// Snaps a 24-bit colour onto the three RGBSort levels per channel.
module rgb_quantize
    import klotski_pkg::*;
(
    input  logic [23:0] i_rgb,
    output logic [23:0] o_rgb
);

    rgb_t in_s;
    rgb_t q_s;

    // Per-channel threshold snap.
    always_comb begin
        in_s   = rgb_t'(i_rgb);
        q_s.r  = quant_chan(in_s.r);
        q_s.g  = quant_chan(in_s.g);
        q_s.b  = quant_chan(in_s.b);
    end

    assign o_rgb = q_s;

endmodule

// File: rtl/rgb_block_avg.sv
// Averages a centred window of each 4x4 grid tile over one frame.
// Optional build macro: RGB_QUANT_EN (quantise latched averages to RGBSort levels).
module rgb_block_avg
    import klotski_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int X0        = 64,
    parameter int Y0        = 0,
    parameter int TILE_LOG2 = 7,
    parameter int WIN_LOG2  = 6
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_valid,
    input  logic [10:0] i_x,
    input  logic [9:0]  i_y,
    input  logic [23:0] i_rgb,
    output logic [23:0] o_block0,
    output logic [23:0] o_block1,
    output logic [23:0] o_block2,
    output logic [23:0] o_block3,
    output logic [23:0] o_block4,
    output logic [23:0] o_block5,
    output logic [23:0] o_block6,
    output logic [23:0] o_block7,
    output logic [23:0] o_block8,
    output logic [23:0] o_block9,
    output logic [23:0] o_block10,
    output logic [23:0] o_block11,
    output logic [23:0] o_block12,
    output logic [23:0] o_block13,
    output logic [23:0] o_block14,
    output logic [23:0] o_block15,
    output logic        o_done
);

    localparam int ACC_W  = 8 + 2 * WIN_LOG2;
    localparam int TILE   = 1 << TILE_LOG2;
    localparam int WIN    = 1 << WIN_LOG2;
    localparam int MARGIN = (TILE - WIN) / 2;

    localparam logic [10:0] X_ORG  = 11'(X0);
    localparam logic [10:0] X_SPAN = 11'(GRID * TILE);
    localparam logic [10:0] X_LIM  = 11'(H_ACTIVE);
    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_ORG  = 10'(Y0);
    localparam logic [9:0]  Y_SPAN = 10'(GRID * TILE);
    localparam logic [9:0]  Y_LIM  = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [TILE_LOG2-1:0] WIN_LO = TILE_LOG2'(MARGIN);
    localparam logic [TILE_LOG2-1:0] WIN_HI = TILE_LOG2'(MARGIN + WIN);

    rgb_avg_state_t state_r, state_next_s;

    logic [10:0] dx_s;
    logic [9:0]  dy_s;
    logic        in_grid_s, in_win_s, sof_s, last_s;
    logic [3:0]  tile_s;
    logic        clr_s, pipe_load_s, latch_s;

    logic        pipe_vld_r, pipe_win_r;
    logic [3:0]  pipe_tile_r;
    logic [23:0] pipe_rgb_r;

    logic [ACC_W-1:0] acc_r [NUM_BLOCKS][3];
    logic [23:0]      avg_s [NUM_BLOCKS];
    logic [23:0]      blk_next_s [NUM_BLOCKS];
    logic [23:0]      blk_r [NUM_BLOCKS];
    logic             done_r;

    // Pixel-to-tile mapping; the unsigned offset wraps for pixels left of or above the grid.
    always_comb begin
        dx_s      = i_x - X_ORG;
        dy_s      = i_y - Y_ORG;
        in_grid_s = (i_x >= X_ORG) && (dx_s < X_SPAN) && (i_x < X_LIM) &&
                    (i_y >= Y_ORG) && (dy_s < Y_SPAN) && (i_y < Y_LIM);
        tile_s    = {dy_s[TILE_LOG2 +: 2], dx_s[TILE_LOG2 +: 2]};
        in_win_s  = in_grid_s &&
                    (dx_s[TILE_LOG2-1:0] >= WIN_LO) && (dx_s[TILE_LOG2-1:0] < WIN_HI) &&
                    (dy_s[TILE_LOG2-1:0] >= WIN_LO) && (dy_s[TILE_LOG2-1:0] < WIN_HI);
        sof_s     = i_valid && (i_x == 11'd0) && (i_y == 10'd0);
        last_s    = i_valid && (i_x == X_LAST) && (i_y == Y_LAST);
    end

    // Capture state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and control strobes; a start request overrides everything, including the last pixel.
    always_comb begin
        state_next_s = state_r;
        clr_s        = 1'b0;
        pipe_load_s  = 1'b0;
        latch_s      = 1'b0;
        if (i_start) begin
            state_next_s = WAIT_SOF;
            clr_s        = 1'b1;
        end else begin
            case (state_r)
                IDLE: state_next_s = IDLE;
                WAIT_SOF: begin
                    if (sof_s) begin
                        state_next_s = ACCUM;
                        pipe_load_s  = 1'b1;
                    end else begin
                        state_next_s = WAIT_SOF;
                    end
                end
                ACCUM: begin
                    pipe_load_s  = i_valid;
                    state_next_s = last_s ? LATCH : ACCUM;
                end
                LATCH: begin
                    if (pipe_vld_r) begin
                        state_next_s = LATCH;
                    end else begin
                        latch_s      = 1'b1;
                        state_next_s = DONE;
                    end
                end
                DONE:    state_next_s = DONE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // One-stage pixel pipeline ahead of the accumulators.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_vld_r  <= 1'b0;
            pipe_win_r  <= 1'b0;
            pipe_tile_r <= 4'd0;
            pipe_rgb_r  <= 24'h000000;
        end else begin
            pipe_vld_r  <= pipe_load_s;
            pipe_win_r  <= in_win_s;
            pipe_tile_r <= tile_s;
            pipe_rgb_r  <= i_rgb;
        end
    end

    // Per-tile channel sums; channel 0 is red.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int t = 0; t < NUM_BLOCKS; t++) begin
                for (int c = 0; c < 3; c++) begin
                    acc_r[t][c] <= {ACC_W{1'b0}};
                end
            end
        end else begin
            for (int t = 0; t < NUM_BLOCKS; t++) begin
                for (int c = 0; c < 3; c++) begin
                    if (clr_s) begin
                        acc_r[t][c] <= {ACC_W{1'b0}};
                    end else if (pipe_vld_r && pipe_win_r && (pipe_tile_r == 4'(t))) begin
                        acc_r[t][c] <= acc_r[t][c] + ACC_W'(pipe_rgb_r[16 - 8 * c +: 8]);
                    end else begin
                        acc_r[t][c] <= acc_r[t][c];
                    end
                end
            end
        end
    end

    // The window holds 2^(2*WIN_LOG2) pixels, so the top byte of each sum is the exact mean.
    for (genvar g = 0; g < NUM_BLOCKS; g++) begin : g_avg
        assign avg_s[g] = {acc_r[g][0][ACC_W-1 -: 8],
                           acc_r[g][1][ACC_W-1 -: 8],
                           acc_r[g][2][ACC_W-1 -: 8]};
`ifdef RGB_QUANT_EN
        rgb_quantize u_quant (
            .i_rgb (avg_s[g]),
            .o_rgb (blk_next_s[g])
        );
`else
        assign blk_next_s[g] = avg_s[g];
`endif
    end

    // Result registers, only written when a capture completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int t = 0; t < NUM_BLOCKS; t++) begin
                blk_r[t] <= 24'h000000;
            end
        end else begin
            for (int t = 0; t < NUM_BLOCKS; t++) begin
                blk_r[t] <= latch_s ? blk_next_s[t] : blk_r[t];
            end
        end
    end

    // Done flag: rises the cycle after entering DONE, drops as soon as a start is sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == DONE) && !i_start;
        end
    end

    assign o_done    = done_r;
    assign o_block0  = blk_r[0];
    assign o_block1  = blk_r[1];
    assign o_block2  = blk_r[2];
    assign o_block3  = blk_r[3];
    assign o_block4  = blk_r[4];
    assign o_block5  = blk_r[5];
    assign o_block6  = blk_r[6];
    assign o_block7  = blk_r[7];
    assign o_block8  = blk_r[8];
    assign o_block9  = blk_r[9];
    assign o_block10 = blk_r[10];
    assign o_block11 = blk_r[11];
    assign o_block12 = blk_r[12];
    assign o_block13 = blk_r[13];
    assign o_block14 = blk_r[14];
    assign o_block15 = blk_r[15];

endmodule

// File: tb/tb_rgb_block_avg.sv
// Self-checking bench for rgb_block_avg on a reduced frame geometry, plus rgb_quantize standalone.
module tb_rgb_block_avg;

    localparam int H   = 40;
    localparam int V   = 36;
    localparam int GX0 = 4;
    localparam int GY0 = 2;
    localparam int TL  = 3;
    localparam int WL  = 2;
    localparam int T   = 1 << TL;
    localparam int W   = 1 << WL;
    localparam int M   = (T - W) / 2;

    logic        clk;
    logic        rst_n, start, valid;
    logic [10:0] px;
    logic [9:0]  py;
    logic [23:0] rgb;
    wire  logic [23:0] ob [16];
    wire  logic        done;
    logic [23:0] q_in;
    wire  logic [23:0] q_out;

    logic [23:0] fb [V][H];
    logic [23:0] exp_blk [16];
    logic [23:0] prev_blk [16];
    int n_checks = 0;
    int n_pass   = 0;
    int perm [16] = '{9, 5, 3, 7, 14, 0, 11, 2, 15, 6, 1, 13, 4, 10, 8, 12};

    rgb_block_avg #(
        .H_ACTIVE(H), .V_ACTIVE(V), .X0(GX0), .Y0(GY0), .TILE_LOG2(TL), .WIN_LOG2(WL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
        .i_x(px), .i_y(py), .i_rgb(rgb),
        .o_block0(ob[0]),   .o_block1(ob[1]),   .o_block2(ob[2]),   .o_block3(ob[3]),
        .o_block4(ob[4]),   .o_block5(ob[5]),   .o_block6(ob[6]),   .o_block7(ob[7]),
        .o_block8(ob[8]),   .o_block9(ob[9]),   .o_block10(ob[10]), .o_block11(ob[11]),
        .o_block12(ob[12]), .o_block13(ob[13]), .o_block14(ob[14]), .o_block15(ob[15]),
        .o_done(done)
    );

    rgb_quantize u_q (.i_rgb(q_in), .o_rgb(q_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mean of each tile's centred W x W window, by plain arithmetic over the frame.
    function automatic void model();
        int sum [16][3];
        for (int k = 0; k < 16; k++) for (int c = 0; c < 3; c++) sum[k][c] = 0;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                int dx = xx - GX0;
                int dy = yy - GY0;
                if (dx >= 0 && dy >= 0 && dx < 4 * T && dy < 4 * T &&
                    (dx % T) >= M && (dx % T) < M + W && (dy % T) >= M && (dy % T) < M + W) begin
                    int k = (dy / T) * 4 + (dx / T);
                    sum[k][0] += int'(fb[yy][xx][23:16]);
                    sum[k][1] += int'(fb[yy][xx][15:8]);
                    sum[k][2] += int'(fb[yy][xx][7:0]);
                end
            end
        end
        for (int k = 0; k < 16; k++)
            exp_blk[k] = {8'(sum[k][0] / (W * W)), 8'(sum[k][1] / (W * W)), 8'(sum[k][2] / (W * W))};
    endfunction

    function automatic void fill_random();
        for (int yy = 0; yy < V; yy++) for (int xx = 0; xx < H; xx++) fb[yy][xx] = 24'($urandom);
    endfunction

    function automatic logic [23:0] code_of(input int k);
        logic [7:0] lv [3];
        lv[0] = 8'h00; lv[1] = 8'h7F; lv[2] = 8'hFF;
        return {lv[k % 3], lv[(k / 3) % 3], lv[(k / 9) % 3]};
    endfunction

    function automatic logic [7:0] qref(input int v);
        if (v < 64) return 8'h00;
        else if (v < 192) return 8'h7F;
        else return 8'hFF;
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Streams rows 0..rows-1 of fb with random idle gaps; returns just after the last pixel is sampled.
    task automatic send_frame(input int gap_pct, input int rows, input bit start_last);
        for (int yy = 0; yy < rows; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                while (int'($urandom_range(99)) < gap_pct) begin
                    @(negedge clk);
                    valid = 1'b0; px = 11'($urandom); py = 10'($urandom); rgb = 24'($urandom);
                end
                @(negedge clk);
                valid = 1'b1; px = 11'(xx); py = 10'(yy); rgb = fb[yy][xx];
                if (start_last && yy == V - 1 && xx == H - 1) start = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; px = 11'd0; py = 10'd0; rgb = 24'h000000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== 24'h000000) $display("FAIL reset_blk%0d: got %06h expected 000000", k, ob[k]);
            else n_pass++;
        end
        fill_random();
        send_frame(0, V, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL nostart_done: got %b expected 0", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== 24'h000000) $display("FAIL nostart_blk%0d: got %06h expected 000000", k, ob[k]);
            else n_pass++;
        end
    endtask

    task automatic test_solid();
        for (int yy = 0; yy < V; yy++) for (int xx = 0; xx < H; xx++) fb[yy][xx] = 24'h7F00FF;
        pulse_start();
        send_frame(0, V, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL solid_done_early: got %b expected 0", done); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL solid_done_lat3: got %b expected 1", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== 24'h7F00FF) $display("FAIL solid_blk%0d: got %06h expected 7F00FF", k, ob[k]);
            else n_pass++;
        end
    endtask

    task automatic test_codes();
        @(negedge clk); start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        n_checks++;
        if (done !== 1'b0) $display("FAIL codes_done_fall: got %b expected 0", done); else n_pass++;
        n_checks++;
        if (ob[7] !== 24'h7F00FF) $display("FAIL codes_hold: got %06h expected 7F00FF", ob[7]); else n_pass++;
        fill_random();
        for (int k = 0; k < 16; k++)
            for (int oy = M; oy < M + W; oy++)
                for (int ox = M; ox < M + W; ox++)
                    fb[GY0 + (k / 4) * T + oy][GX0 + (k % 4) * T + ox] = code_of(perm[k]);
        send_frame(0, V, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL codes_done: got %b expected 1", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== code_of(perm[k]))
                $display("FAIL codes_blk%0d: got %06h expected %06h", k, ob[k], code_of(perm[k]));
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        fill_random();
        model();
        pulse_start();
        send_frame(50, V, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL gaps_done: got %b expected 1", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== exp_blk[k]) $display("FAIL gaps_blk%0d: got %06h expected %06h", k, ob[k], exp_blk[k]);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        for (int k = 0; k < 16; k++) prev_blk[k] = exp_blk[k];
        fill_random();
        pulse_start();
        send_frame(0, 12, 1'b0);
        n_checks++;
        if (done !== 1'b0) $display("FAIL restart_done_mid: got %b expected 0", done); else n_pass++;
        fill_random();
        model();
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== prev_blk[k]) $display("FAIL restart_hold%0d: got %06h expected %06h", k, ob[k], prev_blk[k]);
            else n_pass++;
        end
        send_frame(30, V, 1'b0);
        n_checks++;
        if (done !== 1'b0) $display("FAIL restart_done_between: got %b expected 0", done); else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL restart_done: got %b expected 1", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== exp_blk[k]) $display("FAIL restart_blk%0d: got %06h expected %06h", k, ob[k], exp_blk[k]);
            else n_pass++;
        end
    endtask

    task automatic test_start_on_last();
        for (int k = 0; k < 16; k++) prev_blk[k] = exp_blk[k];
        fill_random();
        model();
        pulse_start();
        send_frame(0, V, 1'b1);
        repeat (5) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL laststart_done: got %b expected 0", done); else n_pass++;
        n_checks++;
        if (ob[10] !== prev_blk[10]) $display("FAIL laststart_hold: got %06h expected %06h", ob[10], prev_blk[10]);
        else n_pass++;
        send_frame(0, V, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL laststart_done2: got %b expected 1", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== exp_blk[k]) $display("FAIL laststart_blk%0d: got %06h expected %06h", k, ob[k], exp_blk[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        model();
        pulse_start();
        send_frame(50, 20, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== 24'h000000) $display("FAIL rstmid_blk%0d: got %06h expected 000000", k, ob[k]);
            else n_pass++;
        end
        @(negedge clk); rst_n = 1'b1;
        pulse_start();
        send_frame(0, V, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) $display("FAIL rstmid_done2: got %b expected 1", done); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (ob[k] !== exp_blk[k]) $display("FAIL rstmid_blk2_%0d: got %06h expected %06h", k, ob[k], exp_blk[k]);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL rstdone_done: got %b expected 0", done); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_quantize();
        logic [7:0] bnd [8];
        logic [23:0] e;
        bnd = '{8'h00, 8'h3F, 8'h40, 8'h41, 8'h7F, 8'hBF, 8'hC0, 8'hFF};
        for (int i = 0; i < 24; i++) begin
            if (i < 8) q_in = {bnd[i], bnd[7 - i], bnd[(i + 3) % 8]};
            else q_in = 24'($urandom);
            #1;
            e = {qref(int'(q_in[23:16])), qref(int'(q_in[15:8])), qref(int'(q_in[7:0]))};
            n_checks++;
            if (q_out !== e) $display("FAIL quant_%0d: in %06h got %06h expected %06h", i, q_in, q_out, e);
            else n_pass++;
        end
    endtask

    initial begin
        q_in = 24'h000000;
        test_reset();
        test_solid();
        test_codes();
        test_gaps();
        test_restart();
        test_start_on_last();
        test_reset_mid();
        test_quantize();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
